// File: rtl/sad_pkg.sv
// Shared constants and FSM state type for the SAD engine blocks.
package sad_pkg;

  localparam int SAD_DEPTH  = 16;
  localparam int SAD_DATA_W = 8;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LAUNCH = 2'd1,
    SERVE  = 2'd2
  } sad_mem_state_t;

endpackage

// File: rtl/sad_pix_ram.sv
// Pixel-pair register array: one synchronous write port, one combinational read port.
module sad_pix_ram
  import sad_pkg::*;
#(
  parameter int WIDTH  = 2 * SAD_DATA_W,
  parameter int DEPTH  = SAD_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sad_ab_mem.sv
// Dual A/B pixel-block store: fills from the host, launches the SAD controller,
// then serves its zero-latency reads until the controller signals completion.
module sad_ab_mem
  import sad_pkg::*;
#(
  parameter int DATA_W = SAD_DATA_W,
  parameter int DEPTH  = SAD_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_a,
  input  logic [DATA_W-1:0] wr_b,
  output logic              go,
  input  logic              AB_rd,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic [DATA_W-1:0] a_data,
  output logic [DATA_W-1:0] b_data,
  input  logic              sad_reg_ld,
  output logic              busy,
  output logic              seq_err,
  output logic [15:0]       frames
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W + 1)'(DEPTH - 1);

  sad_mem_state_t    state_reg, state_next;
  logic [ADDR_W:0]   fill_cnt_reg, fill_cnt_next;
  logic [ADDR_W:0]   rd_cnt_reg, rd_cnt_next;
  logic [ADDR_W:0]   rd_cnt_plus;
  logic [15:0]       frames_reg, frames_next;
  logic              go_reg, go_next;
  logic              seq_err_reg, seq_err_next;
  logic              wr_en;
  logic              rd_oob;
  logic              proto_err;
  logic [2*DATA_W-1:0] rd_word;

  assign wr_ready = (state_reg == FILL);
  assign wr_en    = wr_ready && wr_valid;
  assign rd_oob   = ({1'b0, rd_idx} >= DEPTH_C);

  // A read in the same cycle as completion counts toward the expected total.
  assign rd_cnt_plus = rd_cnt_reg + {{ADDR_W{1'b0}}, AB_rd};

  assign proto_err = (AB_rd && ((state_reg != SERVE) || rd_oob)) ||
                     (sad_reg_ld && ((state_reg != SERVE) || (rd_cnt_plus != DEPTH_C)));

  always_comb begin
    state_next    = state_reg;
    fill_cnt_next = fill_cnt_reg;
    rd_cnt_next   = rd_cnt_reg;
    frames_next   = frames_reg;
    go_next       = 1'b0;
    seq_err_next  = seq_err_reg | proto_err;
    case (state_reg)
      FILL: begin
        if (wr_valid) begin
          if (fill_cnt_reg == LAST_C) begin
            fill_cnt_next = '0;
            state_next    = LAUNCH;
            go_next       = 1'b1;
          end else begin
            fill_cnt_next = fill_cnt_reg + 1'b1;
          end
        end
      end
      LAUNCH: state_next = SERVE;
      SERVE: begin
        if (AB_rd) begin
          rd_cnt_next = rd_cnt_plus;
        end
        if (sad_reg_ld) begin
          frames_next = frames_reg + 16'd1;
          rd_cnt_next = '0;
          state_next  = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= FILL;
      fill_cnt_reg <= '0;
      rd_cnt_reg   <= '0;
      frames_reg   <= '0;
      go_reg       <= 1'b0;
      seq_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fill_cnt_reg <= fill_cnt_next;
      rd_cnt_reg   <= rd_cnt_next;
      frames_reg   <= frames_next;
      go_reg       <= go_next;
      seq_err_reg  <= seq_err_next;
    end
  end

  sad_pix_ram #(
    .WIDTH  (2 * DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we      (wr_en),
    .wr_addr (fill_cnt_reg[ADDR_W-1:0]),
    .wr_data ({wr_b, wr_a}),
    .rd_addr (rd_idx),
    .rd_data (rd_word)
  );

  assign a_data  = rd_oob ? '0 : rd_word[DATA_W-1:0];
  assign b_data  = rd_oob ? '0 : rd_word[2*DATA_W-1:DATA_W];
  assign go      = go_reg;
  assign busy    = (state_reg != FILL);
  assign seq_err = seq_err_reg;
  assign frames  = frames_reg;

endmodule

// File: tb/tb_sad_ab_mem.sv
// Directed bench for sad_ab_mem: host fill model, controller read model and a
// scoreboard of expected pixel pairs compared as the store answers each read.
module tb_sad_ab_mem;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_a, wr_b;
  logic       go;
  logic       AB_rd;
  logic [3:0] rd_idx;
  logic [7:0] a_data, b_data;
  logic       sad_reg_ld;
  logic       busy;
  logic       seq_err;
  logic [15:0] frames;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  model_a [16];
  logic [7:0]  model_b [16];
  logic [15:0] sb_q [$];

  always #5 clk = ~clk;

  sad_ab_mem dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_a       (wr_a),
    .wr_b       (wr_b),
    .go         (go),
    .AB_rd      (AB_rd),
    .rd_idx     (rd_idx),
    .a_data     (a_data),
    .b_data     (b_data),
    .sad_reg_ld (sad_reg_ld),
    .busy       (busy),
    .seq_err    (seq_err),
    .frames     (frames)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  // Push one frame of beats; max_gap>0 inserts random idle cycles before beats.
  task automatic fill_frame(input int off, input int max_gap, input bit hold_after);
    for (int k = 0; k < 16; k++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      wr_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        check("go_idle", 32'(go), 32'd0);
        cyc();
      end
      model_a[k] = 8'(k + off);
      model_b[k] = 8'(2 * k + off);
      wr_valid = 1'b1;
      wr_a = model_a[k];
      wr_b = model_b[k];
      check("go_low_fill", 32'(go), 32'd0);
      check("wr_ready_fill", 32'(wr_ready), 32'd1);
      cyc();
    end
    if (hold_after) begin
      wr_a = 8'hFF;
      wr_b = 8'hFF;
    end else begin
      wr_valid = 1'b0;
    end
    check("go_launch", 32'(go), 32'd1);
    check("wr_ready_launch", 32'(wr_ready), 32'd0);
    cyc();
    check("go_one_cycle", 32'(go), 32'd0);
    check("busy_serve", 32'(busy), 32'd1);
  endtask

  // Controller model: n reads at idx 0..n-1, then the completion strobe.
  task automatic serve(input int n, input logic exp_err, input logic [15:0] exp_frames);
    for (int i = 0; i < n; i++) begin
      AB_rd  = 1'b1;
      rd_idx = 4'(i);
      sb_q.push_back({model_b[i], model_a[i]});
      #1;
      check("rd_pair", {16'd0, b_data, a_data}, {16'd0, sb_q.pop_front()});
      check("wr_ready_serve", 32'(wr_ready), 32'd0);
      cyc();
    end
    AB_rd = 1'b0;
    sad_reg_ld = 1'b1;
    cyc();
    sad_reg_ld = 1'b0;
    check("wr_ready_after_ld", 32'(wr_ready), 32'd1);
    check("busy_after_ld", 32'(busy), 32'd0);
    check("frames", 32'(frames), 32'(exp_frames));
    check("seq_err", 32'(seq_err), 32'(exp_err));
  endtask

  initial begin
    rst = 1'b0; wr_valid = 1'b0; wr_a = '0; wr_b = '0;
    AB_rd = 1'b0; rd_idx = '0; sad_reg_ld = 1'b0;
    cyc();
    do_reset();
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_go", 32'(go), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_seq_err", 32'(seq_err), 32'd0);
    check("rst_frames", 32'(frames), 32'd0);

    // Basic fill/launch/serve.
    fill_frame(0, 0, 1'b0);
    serve(16, 1'b0, 16'd1);

    // Backpressure: wr_valid held high with 0xFF through LAUNCH/SERVE.
    fill_frame(0, 0, 1'b1);
    serve(16, 1'b0, 16'd2);
    // Refill must start at index 0 for the new pattern to read back aligned.
    fill_frame(5, 0, 1'b0);
    serve(16, 1'b0, 16'd3);

    // AB_rd in FILL sets a sticky error.
    AB_rd = 1'b1; rd_idx = 4'd3;
    cyc();
    AB_rd = 1'b0;
    check("err_rd_in_fill", 32'(seq_err), 32'd1);
    cyc(); cyc();
    check("err_sticky", 32'(seq_err), 32'd1);

    // Early completion: still returns to FILL and counts the frame.
    do_reset();
    check("err_cleared", 32'(seq_err), 32'd0);
    fill_frame(1, 0, 1'b0);
    serve(15, 1'b1, 16'd1);

    // Reset in the middle of SERVE aborts the frame.
    do_reset();
    fill_frame(2, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      AB_rd = 1'b1;
      rd_idx = 4'(i);
      cyc();
    end
    AB_rd = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_go", 32'(go), 32'd0);
    check("abort_frames", 32'(frames), 32'd0);
    check("abort_wr_ready", 32'(wr_ready), 32'd1);
    fill_frame(3, 0, 1'b0);
    serve(16, 1'b0, 16'd1);

    // Gapped fills across three frames.
    do_reset();
    for (int f = 1; f <= 3; f++) begin
      fill_frame(f * 7, 2, 1'b0);
      serve(16, 1'b0, 16'(f));
    end

    // Frame counter wrap.
    force dut.frames_reg = 16'hFFFF;
    cyc();
    release dut.frames_reg;
    check("frames_forced", 32'(frames), 32'hFFFF);
    fill_frame(9, 0, 1'b0);
    serve(16, 1'b0, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
